// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Segment encoding is active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex-to-segment table: entry 0 is the right-most literal.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        segments = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Multiplexed scan of NUM_DIGITS hex digits onto one seven-segment display.
// A single-clock prescaler paces the digit rotation; every digit change is
// preceded by BLANK_CYCLES clocks with all anodes off to avoid ghosting.
// Output registers are loaded from next-state values so that anode/segment
// timing is aligned with the FSM state and inputs see one clock of latency.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module display_scan_scheduler
    import seven_seg_pkg::*;
#(
    parameter int  NUM_DIGITS    = 4,
    parameter int  PRESCALE_BITS = 17,
    parameter int  BLANK_CYCLES  = 16,
    localparam int SEL_W         = $clog2(NUM_DIGITS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic [SEL_W-1:0]        digit_sel,
    output logic                    scan_tick
);

    localparam logic [PRESCALE_BITS-1:0] PRESCALE_MAX = '1;
    localparam logic [PRESCALE_BITS-1:0] BLANK_LAST   = PRESCALE_BITS'(BLANK_CYCLES - 1);
    localparam logic [SEL_W-1:0]         SEL_LAST     = SEL_W'(NUM_DIGITS - 1);

    scan_state_e               state_r, state_nxt_s;
    logic [PRESCALE_BITS-1:0]  prescale_r, prescale_nxt_s;
    logic [PRESCALE_BITS-1:0]  blank_cnt_r, blank_cnt_nxt_s;
    logic [SEL_W-1:0]          digit_sel_r, digit_sel_nxt_s;
    logic                      wrap_s;
    logic                      scan_tick_r;

    logic [NUM_DIGITS-1:0]     anode_r, anode_nxt_s;
    logic [6:0]                segment_r, segment_nxt_s;
    logic                      dp_r, dp_nxt_s;

    logic [3:0]                nibble_s;
    logic [6:0]                dec_seg_s;
    logic                      suppress_s;

    // Prescaler wrap is only meaningful while scanning.
    always_comb begin
        wrap_s = (state_r != IDLE) && (prescale_r == PRESCALE_MAX);
    end

    // Next-state logic: FSM, prescaler, blank counter and digit index.
    always_comb begin
        state_nxt_s     = state_r;
        prescale_nxt_s  = prescale_r;
        blank_cnt_nxt_s = blank_cnt_r;
        digit_sel_nxt_s = digit_sel_r;
        if (!enable) begin
            state_nxt_s     = IDLE;
            prescale_nxt_s  = '0;
            blank_cnt_nxt_s = '0;
            digit_sel_nxt_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s     = BLANK;
                    prescale_nxt_s  = '0;
                    blank_cnt_nxt_s = '0;
                    digit_sel_nxt_s = '0;
                end
                BLANK: begin
                    // A wrap here is ignored; the prescaler just keeps running.
                    prescale_nxt_s = prescale_r + PRESCALE_BITS'(1);
                    if (blank_cnt_r == BLANK_LAST) begin
                        state_nxt_s     = DRIVE;
                        blank_cnt_nxt_s = '0;
                    end else begin
                        blank_cnt_nxt_s = blank_cnt_r + PRESCALE_BITS'(1);
                    end
                end
                DRIVE: begin
                    prescale_nxt_s = prescale_r + PRESCALE_BITS'(1);
                    if (wrap_s) begin
                        state_nxt_s     = BLANK;
                        blank_cnt_nxt_s = '0;
                        digit_sel_nxt_s = (digit_sel_r == SEL_LAST) ? '0
                                          : digit_sel_r + SEL_W'(1);
                    end else begin
                        state_nxt_s = DRIVE;
                    end
                end
                default: begin
                    state_nxt_s     = IDLE;
                    prescale_nxt_s  = '0;
                    blank_cnt_nxt_s = '0;
                    digit_sel_nxt_s = '0;
                end
            endcase
        end
    end

    // Digit mux: select the nibble of the digit about to be driven.
    always_comb begin
        nibble_s = digits_in[{digit_sel_nxt_s, 2'b00} +: 4];
    end

    seg7_hex_decoder u_decoder (
        .nibble   (nibble_s),
        .segments (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] upper_zero_s;

    // upper_zero_s[k] is set when digits k..NUM_DIGITS-1 are all zero.
    always_comb begin
        upper_zero_s = '0;
        upper_zero_s[NUM_DIGITS-1] = (digits_in[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            upper_zero_s[k] = upper_zero_s[k+1] && (digits_in[4*k +: 4] == 4'h0);
        end
    end

    // Leading zeros without a decimal point stay dark; digit 0 always shows.
    always_comb begin
        if (digit_sel_nxt_s != '0) begin
            suppress_s = upper_zero_s[digit_sel_nxt_s] && !dp_in[digit_sel_nxt_s];
        end else begin
            suppress_s = 1'b0;
        end
    end
`else
    // Every digit is displayed, leading zeros included.
    always_comb begin
        suppress_s = 1'b0;
    end
`endif

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        anode_nxt_s   = '1;
        segment_nxt_s = SEG_BLANK;
        dp_nxt_s      = 1'b1;
        if ((state_nxt_s == DRIVE) && !suppress_s) begin
            anode_nxt_s[digit_sel_nxt_s] = 1'b0;
            segment_nxt_s                = dec_seg_s;
            dp_nxt_s                     = ~dp_in[digit_sel_nxt_s];
        end else begin
            anode_nxt_s   = '1;
            segment_nxt_s = SEG_BLANK;
            dp_nxt_s      = 1'b1;
        end
    end

    // State, counter and output registers; reset darkens the display at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            prescale_r  <= '0;
            blank_cnt_r <= '0;
            digit_sel_r <= '0;
            scan_tick_r <= 1'b0;
            anode_r     <= '1;
            segment_r   <= SEG_BLANK;
            dp_r        <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            prescale_r  <= prescale_nxt_s;
            blank_cnt_r <= blank_cnt_nxt_s;
            digit_sel_r <= digit_sel_nxt_s;
            scan_tick_r <= wrap_s;
            anode_r     <= anode_nxt_s;
            segment_r   <= segment_nxt_s;
            dp_r        <= dp_nxt_s;
        end
    end

    assign anode     = anode_r;
    assign segment   = segment_r;
    assign dp        = dp_r;
    assign digit_sel = digit_sel_r;
    assign scan_tick = scan_tick_r;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler (4 digits, 16-clock period,
// 2 blank clocks). Expected digit frames are queued when inputs are set and
// popped each time a new digit lights up.
module tb_display_scan_scheduler;

    localparam int N = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int         sel;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        int         lit_exp;
        int         dark_exp;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  anode;
    logic [6:0]  segment;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        scan_tick;

    exp_t sb_q[$];
    int   checks_n = 0;
    int   fail_n   = 0;

    display_scan_scheduler #(
        .NUM_DIGITS    (4),
        .PRESCALE_BITS (4),
        .BLANK_CYCLES  (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .anode     (anode),
        .segment   (segment),
        .dp        (dp),
        .digit_sel (digit_sel),
        .scan_tick (scan_tick)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(int k, logic [15:0] dig, logic [3:0] dpv, int lit_e, int dark_e);
        exp_t       e;
        logic [3:0] a;
        logic [3:0] nib;
        a      = 4'hF;
        a[k]   = 1'b0;
        nib    = dig[4*k +: 4];
        e.sel      = k;
        e.anode    = a;
        e.seg      = SEG_TAB[nib];
        e.dp       = ~dpv[k];
        e.lit_exp  = lit_e;
        e.dark_exp = dark_e;
        return e;
    endfunction

    // From a negedge sample, count lit samples until dark, then dark until lit.
    task automatic measure(output int lit_n, output int dark_n);
        lit_n  = 0;
        dark_n = 0;
        while (anode != 4'hF && lit_n < 100) begin
            @(negedge clock);
            lit_n++;
        end
        while (anode == 4'hF && dark_n < 100) begin
            @(negedge clock);
            dark_n++;
        end
    endtask

    task automatic run_sb(input int count);
        exp_t e;
        int   lit_n;
        int   dark_n;
        for (int i = 0; i < count; i++) begin
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                measure(lit_n, dark_n);
                if (e.lit_exp >= 0) check_val("lit_clocks", lit_n, e.lit_exp);
                check_val("dark_clocks", dark_n, e.dark_exp);
                check_val("anode", anode, e.anode);
                check_val("segment", segment, e.seg);
                check_val("dp", dp, e.dp);
                check_val("digit_sel", digit_sel, e.sel);
            end
        end
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        enable    = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0001;
        #1 reset  = 1'b0;

        // Held in reset with enable high: display dark.
        repeat (3) @(negedge clock);
        check_val("rst_anode", anode, 4'hF);
        check_val("rst_segment", segment, 7'h7F);
        check_val("rst_dp", dp, 1'b1);
        check_val("rst_tick", scan_tick, 1'b0);
        check_val("rst_sel", digit_sel, 2'd0);

        // Two full rounds of 1234, then digit 0..2 of a third.
        sb_q.push_back(model(0, digits_in, dp_in, -1, 3));
        for (int k = 1; k < 4; k++) sb_q.push_back(model(k, digits_in, dp_in, 14, 2));
        for (int k = 0; k < 4; k++) sb_q.push_back(model(k, digits_in, dp_in, 14, 2));
        for (int k = 0; k < 3; k++) sb_q.push_back(model(k, digits_in, dp_in, 14, 2));
        reset = 1'b1;
        run_sb(11);

        // Drop enable while digit 2 is driven.
        enable = 1'b0;
        @(negedge clock);
        check_val("dis_anode", anode, 4'hF);
        check_val("dis_sel", digit_sel, 2'd0);
        check_val("dis_segment", segment, 7'h7F);
        repeat (3) @(negedge clock);
        check_val("dis_hold_anode", anode, 4'hF);
        check_val("dis_hold_tick", scan_tick, 1'b0);

        // Re-enable: scan restarts at digit 0.
        enable = 1'b1;
        sb_q.push_back(model(0, digits_in, dp_in, -1, 3));
        run_sb(1);

        // Inputs change mid-digit: one clock latency to the outputs.
        digits_in = 16'h8AF6;
        dp_in     = 4'b1010;
        @(negedge clock);
        check_val("lat_segment", segment, SEG_TAB[6]);
        check_val("lat_dp", dp, 1'b1);
        sb_q.push_back(model(1, digits_in, dp_in, 13, 2));
        sb_q.push_back(model(2, digits_in, dp_in, 14, 2));
        sb_q.push_back(model(3, digits_in, dp_in, 14, 2));
        run_sb(3);

        // Scan tick: single-clock pulse, 16 clocks apart.
        n = 0;
        while (scan_tick != 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_val("tick_seen", scan_tick, 1'b1);
        @(negedge clock);
        check_val("tick_width", scan_tick, 1'b0);
        n = 1;
        while (scan_tick != 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_val("tick_period", n, 16);

        // Asynchronous reset in the middle of a driven digit.
        n = 0;
        while (anode == 4'hF && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_val("pre_async_lit", (anode != 4'hF), 1'b1);
        #2 reset = 1'b0;
        #1;
        check_val("async_anode", anode, 4'hF);
        check_val("async_segment", segment, 7'h7F);
        check_val("async_dp", dp, 1'b1);
        check_val("async_sel", digit_sel, 2'd0);

        // Leading zeros: 0070.
        @(negedge clock);
        digits_in = 16'h0070;
        dp_in     = 4'b0000;
        @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        sb_q.push_back(model(0, digits_in, dp_in, -1, 3));
        sb_q.push_back(model(1, digits_in, dp_in, 14, 2));
        sb_q.push_back(model(0, digits_in, dp_in, 14, 34));
        reset = 1'b1;
        run_sb(3);
`else
        sb_q.push_back(model(0, digits_in, dp_in, -1, 3));
        for (int k = 1; k < 4; k++) sb_q.push_back(model(k, digits_in, dp_in, 14, 2));
        sb_q.push_back(model(0, digits_in, dp_in, 14, 2));
        reset = 1'b1;
        run_sb(5);
`endif
        check_val("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
